// File: rtl/charge_station_ctrl_pkg.sv
// Shared definitions for the charging-station session controller:
// state encoding visible on the display port and coin denominations.
package charge_station_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAY    = 2'd1,
        ST_CHARGE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned COIN_ONE_VAL = 1;
    localparam int unsigned COIN_TEN_VAL = 10;

endpackage

// File: rtl/charge_station_ctrl_tick_gen.sv
// One-second tick generator: down-counter that pulses on terminal count
// and reloads; restart realigns the tick phase to the restart cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned      CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_cnt <= TC_LOAD;
        end else if (r_cnt == '0) begin
            r_cnt <= TC_LOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tick = (r_cnt == '0);

endmodule

// File: rtl/charge_station_ctrl.sv
// Session controller: card opens a session, coins buy credit, start runs a
// timed charge; every session ends with one fin pulse carrying the refund.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | waiting for a fresh card insertion edge
//   ST_PAY    | accepting coins, idle-timeout running
//   ST_CHARGE | charging, credit consumed per SEC_PER_YUAN seconds
//   ST_DONE   | one-cycle fin with refund, then back to IDLE
module charge_station_ctrl
    import charge_station_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned MAX_CREDIT   = 20,
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned SEC_PER_YUAN = 120,
    parameter int unsigned TIMEOUT_S    = 30,
    parameter int unsigned TIME_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                card,
    input  logic                coin_one,
    input  logic                coin_ten,
    input  logic                hi_pwr,
    input  logic                start,
    input  logic                cancel,
    output logic [1:0]          state,
    output logic [CREDIT_W-1:0] credit,
    output logic [TIME_W-1:0]   remain_s,
    output logic                charging,
    output logic                fin,
    output logic [CREDIT_W-1:0] refund
);

    localparam int unsigned UNIT_RAW = $clog2(SEC_PER_YUAN + 1);
    localparam int unsigned UNIT_W   = (UNIT_RAW < 2) ? 2 : UNIT_RAW;
    localparam int unsigned TO_RAW   = $clog2(TIMEOUT_S + 1);
    localparam int unsigned TO_W     = (TO_RAW < 1) ? 1 : TO_RAW;
    localparam int unsigned SUM_W    = CREDIT_W + 5;

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [TIME_W-1:0]   r_remain;
    logic [UNIT_W-1:0]   r_unit;
    logic                r_hi;
    logic [TO_W-1:0]     r_to_cnt;
    logic [CREDIT_W-1:0] r_refund;
    logic                r_card_q;
    logic                r_arm;

    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [TIME_W-1:0]   w_remain_nxt;
    logic [UNIT_W-1:0]   w_unit_nxt;
    logic                w_hi_nxt;
    logic [TO_W-1:0]     w_to_nxt;
    logic [CREDIT_W-1:0] w_refund_nxt;
    logic                w_restart;
    logic                w_tick;
    logic                w_card_rise;
    logic                w_timeout;
    logic [SUM_W-1:0]    w_coin_sum;
    logic [CREDIT_W-1:0] w_coin_credit;
    logic [TIME_W-1:0]   w_charge_time;
    logic [TIME_W-1:0]   w_step_t;
    logic [UNIT_W-1:0]   w_step_u;
    logic [TIME_W-1:0]   w_remain_dec;
    logic [UNIT_W-1:0]   w_unit_dec;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // r_arm blocks the first cycle after reset so a card held through reset
    // never looks like an insertion.
    assign w_card_rise = card && !r_card_q && r_arm;
    assign w_timeout   = w_tick && (r_to_cnt == TO_W'(TIMEOUT_S - 1));

    assign w_coin_sum    = SUM_W'(r_credit)
                         + (coin_one ? SUM_W'(COIN_ONE_VAL) : SUM_W'(0))
                         + (coin_ten ? SUM_W'(COIN_TEN_VAL) : SUM_W'(0));
    assign w_coin_credit = (w_coin_sum > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT)
                                                             : CREDIT_W'(w_coin_sum);
    assign w_charge_time = TIME_W'(32'(r_credit) * SEC_PER_YUAN);

    assign w_step_t     = r_hi ? TIME_W'(2) : TIME_W'(1);
    assign w_step_u     = r_hi ? UNIT_W'(2) : UNIT_W'(1);
    assign w_remain_dec = (r_remain > w_step_t) ? (r_remain - w_step_t) : '0;
    assign w_unit_dec   = (r_unit > w_step_u) ? (r_unit - w_step_u) : '0;

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_remain_nxt = r_remain;
        w_unit_nxt   = r_unit;
        w_hi_nxt     = r_hi;
        w_to_nxt     = r_to_cnt;
        w_refund_nxt = r_refund;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_to_nxt = '0;
                if (w_card_rise) begin
                    w_state_nxt = ST_PAY;
                end
            end
            ST_PAY: begin
                if (cancel || !card || w_timeout) begin
                    w_state_nxt  = ST_DONE;
                    w_refund_nxt = r_credit;
                end else if (start) begin
                    w_to_nxt = '0;
                    if (r_credit != '0) begin
                        w_state_nxt  = ST_CHARGE;
                        w_remain_nxt = w_charge_time;
                        w_unit_nxt   = UNIT_W'(SEC_PER_YUAN);
                        w_hi_nxt     = hi_pwr;
                        w_restart    = 1'b1;
                    end
                end else if (coin_one || coin_ten) begin
                    w_to_nxt     = '0;
                    w_credit_nxt = w_coin_credit;
                end else if (w_tick) begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            ST_CHARGE: begin
                if (cancel || !card) begin
                    w_state_nxt  = ST_DONE;
                    w_refund_nxt = r_credit;
                end else if (w_tick) begin
                    w_remain_nxt = w_remain_dec;
                    // A fully consumed yuan is charged and the next one starts.
                    if (w_unit_dec == '0) begin
                        w_credit_nxt = (r_credit != '0) ? (r_credit - 1'b1) : '0;
                        w_unit_nxt   = UNIT_W'(SEC_PER_YUAN);
                    end else begin
                        w_unit_nxt = w_unit_dec;
                    end
                    if (w_remain_dec == '0) begin
                        w_state_nxt  = ST_DONE;
                        w_refund_nxt = '0;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
                w_remain_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_remain <= '0;
            r_unit   <= '0;
            r_hi     <= 1'b0;
            r_to_cnt <= '0;
            r_refund <= '0;
            r_card_q <= 1'b0;
            r_arm    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_remain <= w_remain_nxt;
            r_unit   <= w_unit_nxt;
            r_hi     <= w_hi_nxt;
            r_to_cnt <= w_to_nxt;
            r_refund <= w_refund_nxt;
            r_card_q <= card;
            r_arm    <= 1'b1;
        end
    end

    assign state    = r_state;
    assign credit   = r_credit;
    assign remain_s = r_remain;
    assign charging = (r_state == ST_CHARGE);
    assign fin      = (r_state == ST_DONE);
    assign refund   = r_refund;

endmodule

// File: tb/tb_charge_station_ctrl.sv
// Bench for charge_station_ctrl: directed session scenarios with literal
// expectations, then randomized traffic checked against a session model.
module tb_charge_station_ctrl;

    localparam int CREDIT_W = 8;
    localparam int MAXC     = 20;
    localparam int TD       = 4;
    localparam int SPY      = 3;
    localparam int TOUT     = 5;
    localparam int TIME_W   = 16;

    localparam int M_IDLE = 0, M_PAY = 1, M_CHARGE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic reset, card, coin_one, coin_ten, hi_pwr, start, cancel;
    logic [1:0]          state;
    logic [CREDIT_W-1:0] credit;
    logic [TIME_W-1:0]   remain_s;
    logic                charging, fin;
    logic [CREDIT_W-1:0] refund;

    charge_station_ctrl #(
        .CREDIT_W     (CREDIT_W),
        .MAX_CREDIT   (MAXC),
        .TICK_DIV     (TD),
        .SEC_PER_YUAN (SPY),
        .TIMEOUT_S    (TOUT),
        .TIME_W       (TIME_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .card     (card),
        .coin_one (coin_one),
        .coin_ten (coin_ten),
        .hi_pwr   (hi_pwr),
        .start    (start),
        .cancel   (cancel),
        .state    (state),
        .credit   (credit),
        .remain_s (remain_s),
        .charging (charging),
        .fin      (fin),
        .refund   (refund)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // Session model: seconds bought, seconds left in the current yuan,
    // idle-tick count, and the tick phase measured since its last origin.
    int  m_state = M_IDLE, m_credit = 0, m_remain = 0, m_unit = 0, m_refund = 0;
    int  m_idle = 0, m_since = 0;
    bit  m_hi = 1'b0, m_prev_card = 1'b0, m_prev_run = 1'b0;

    always @(posedge clk) begin
        bit tick, rise;
        int d;
        if (reset) begin
            m_state = M_IDLE; m_credit = 0; m_remain = 0; m_unit = 0;
            m_refund = 0; m_idle = 0; m_since = 0; m_hi = 1'b0;
            m_prev_card = 1'b0; m_prev_run = 1'b0;
        end else begin
            tick = ((m_since % TD) == TD - 1);
            m_since++;
            rise = card && !m_prev_card && m_prev_run;
            case (m_state)
                M_IDLE: begin
                    m_idle = 0;
                    if (rise) m_state = M_PAY;
                end
                M_PAY: begin
                    if (cancel || !card || (tick && m_idle + 1 >= TOUT)) begin
                        m_state = M_DONE; m_refund = m_credit;
                    end else if (start) begin
                        m_idle = 0;
                        if (m_credit > 0) begin
                            m_state = M_CHARGE; m_remain = m_credit * SPY;
                            m_unit = SPY; m_hi = hi_pwr; m_since = 0;
                        end
                    end else if (coin_one || coin_ten) begin
                        m_idle = 0;
                        m_credit = m_credit + (coin_one ? 1 : 0) + (coin_ten ? 10 : 0);
                        if (m_credit > MAXC) m_credit = MAXC;
                    end else if (tick) begin
                        m_idle++;
                    end
                end
                M_CHARGE: begin
                    if (cancel || !card) begin
                        m_state = M_DONE; m_refund = m_credit;
                    end else if (tick) begin
                        d = m_hi ? 2 : 1;
                        m_remain = (m_remain > d) ? m_remain - d : 0;
                        m_unit   = (m_unit > d) ? m_unit - d : 0;
                        if (m_unit == 0) begin
                            if (m_credit > 0) m_credit--;
                            m_unit = SPY;
                        end
                        if (m_remain == 0) begin
                            m_state = M_DONE; m_refund = 0;
                        end
                    end
                end
                default: begin
                    m_state = M_IDLE; m_credit = 0; m_remain = 0;
                end
            endcase
            m_prev_card = card;
            m_prev_run  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("state",    int'(state),    m_state);
            cmp("credit",   int'(credit),   m_credit);
            cmp("remain_s", int'(remain_s), m_remain);
            cmp("charging", int'(charging), int'(m_state == M_CHARGE));
            cmp("fin",      int'(fin),      int'(m_state == M_DONE));
            cmp("refund",   int'(refund),   m_refund);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic swipe();
        card = 1'b0; step();
        card = 1'b1; step();
    endtask

    task automatic coin(input bit one, input bit ten);
        coin_one = one; coin_ten = ten; step();
        coin_one = 1'b0; coin_ten = 1'b0;
    endtask

    task automatic do_start(input bit hp);
        hi_pwr = hp; start = 1'b1; step();
        start = 1'b0; hi_pwr = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1; step();
        cancel = 1'b0;
    endtask

    initial begin
        int n;
        int fins;
        reset = 1'b1; card = 1'b0; coin_one = 1'b0; coin_ten = 1'b0;
        hi_pwr = 1'b0; start = 1'b0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        cmp("rst_state",  int'(state),  0);
        cmp("rst_credit", int'(credit), 0);
        cmp("rst_remain", int'(remain_s), 0);
        cmp("rst_fin",    int'(fin),    0);
        cmp("rst_refund", int'(refund), 0);

        // 1: normal-rate charge runs to completion
        swipe();
        cmp("t1_pay", int'(state), 1);
        coin(1, 0); coin(1, 0);
        cmp("t1_credit", int'(credit), 2);
        do_start(1'b0);
        cmp("t1_charge", int'(state), 2);
        cmp("t1_remain", int'(remain_s), 6);
        cmp("t1_model_remain", m_remain, 6);
        repeat (3 * TD) step();
        cmp("t1_remain_mid", int'(remain_s), 3);
        cmp("t1_credit_mid", int'(credit), 1);
        repeat (3 * TD) step();
        cmp("t1_fin", int'(fin), 1);
        cmp("t1_refund", int'(refund), 0);
        step();
        cmp("t1_idle", int'(state), 0);
        cmp("t1_fin_low", int'(fin), 0);

        // 2: saturation and simultaneous coins
        swipe();
        coin(0, 1); coin(0, 1); coin(1, 0);
        cmp("t2_sat", int'(credit), 20);
        do_cancel();
        cmp("t2_refund20", int'(refund), 20);
        step();
        swipe();
        repeat (5) coin(1, 0);
        coin(1, 1);
        cmp("t2_both", int'(credit), 16);
        do_cancel();
        cmp("t2_refund16", int'(refund), 16);
        step();

        // 3: high-rate charge cancelled after two ticks
        swipe();
        repeat (3) coin(1, 0);
        do_start(1'b1);
        cmp("t3_remain0", int'(remain_s), 9);
        repeat (2 * TD) step();
        cmp("t3_remain", int'(remain_s), 5);
        cmp("t3_credit", int'(credit), 2);
        do_cancel();
        cmp("t3_fin", int'(fin), 1);
        cmp("t3_refund", int'(refund), 2);
        step();

        // 4: pay timeout, then start with zero credit
        swipe();
        coin(1, 0);
        n = 0;
        while (!fin && n < 40) begin
            step();
            n++;
        end
        cmp("t4_fin_seen", int'(fin), 1);
        cmp("t4_wait_ok", int'(n >= 17 && n <= 20), 1);
        cmp("t4_refund", int'(refund), 1);
        step();
        swipe();
        do_start(1'b0);
        cmp("t4_zero_start", int'(state), 1);
        do_cancel();
        cmp("t4_refund0", int'(refund), 0);
        step();

        // 5: card pulled mid-charge; coin lost against cancel
        swipe();
        repeat (4) coin(1, 0);
        do_start(1'b0);
        card = 1'b0; step();
        cmp("t5_fin", int'(fin), 1);
        cmp("t5_refund", int'(refund), 4);
        step();
        swipe();
        coin(1, 0); coin(1, 0);
        coin_ten = 1'b1; cancel = 1'b1; step();
        coin_ten = 1'b0; cancel = 1'b0;
        cmp("t5_coin_cancel", int'(refund), 2);
        step();

        // 6: reset mid-charge with the card held through release
        swipe();
        coin(1, 0);
        do_start(1'b0);
        repeat (3) step();
        reset = 1'b1; step();
        cmp("t6_state", int'(state), 0);
        cmp("t6_credit", int'(credit), 0);
        cmp("t6_remain", int'(remain_s), 0);
        cmp("t6_refund", int'(refund), 0);
        reset = 1'b0;
        fins = 0;
        repeat (12) begin
            step();
            if (fin) fins++;
        end
        cmp("t6_no_fin", fins, 0);
        cmp("t6_stay_idle", int'(state), 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) card = ~card;
            coin_one = ($urandom_range(0, 99) < 12);
            coin_ten = ($urandom_range(0, 99) < 5);
            start    = ($urandom_range(0, 99) < 6);
            cancel   = ($urandom_range(0, 99) < 2);
            hi_pwr   = $urandom_range(0, 1) == 1;
            reset    = ($urandom_range(0, 999) < 4);
            step();
        end
        reset = 1'b0; coin_one = 1'b0; coin_ten = 1'b0;
        start = 1'b0; cancel = 1'b0; hi_pwr = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/charge_station_ctrl.md
Name: charge_station_ctrl

Overview:
Parametrised session controller for the charging-station design.
- Card swipe opens a session; coins accumulate credit; start begins a timed charge; cancel, timeout or card removal ends it.
- Each session ends with a refund report.
- Replaces the fixed-mode controller: adds configurable credit cap, tariff, dual power rate, pay timeout and partial refund.
- Feeds the display block (state, credit, remain_s) and the refund dispenser (fin, refund).

Parameters:
CREDIT_W, 8, width of the credit and refund registers
MAX_CREDIT, 20, credit saturation cap in yuan
TICK_DIV, 50000000, clk cycles per one-second tick
SEC_PER_YUAN, 120, charge seconds bought by one yuan at normal rate
TIMEOUT_S, 30, idle seconds in PAY before auto-cancel
TIME_W, 16, width of remain_s; must hold MAX_CREDIT*SEC_PER_YUAN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
card  in  1  level, card present; rising edge detected internally
coin_one  in  1  one-cycle pulse, +1 yuan
coin_ten  in  1  one-cycle pulse, +10 yuan
hi_pwr  in  1  rate select, sampled on the start cycle
start  in  1  one-cycle pulse, begin charging
cancel  in  1  one-cycle pulse, user abort
state  out  2  0=IDLE 1=PAY 2=CHARGE 3=DONE
credit  out  CREDIT_W  current unspent whole yuan
remain_s  out  TIME_W  charge seconds remaining
charging  out  1  high while in CHARGE
fin  out  1  one-cycle pulse on entering DONE
refund  out  CREDIT_W  refund amount; valid while fin=1, held until next fin

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, credit=0, remain_s=0, charging=0, fin=0, refund=0. The tick counter, timeout counter and card edge register are also cleared.
- All pulse inputs are synchronous and debounced upstream.
- IDLE:
  - card rising edge -> PAY next cycle.
  - Coins, start and cancel are ignored.
- PAY:
  - coin_one/coin_ten add 1/10. Both in the same cycle add 11.
  - Sum saturates at MAX_CREDIT; there is no wrap.
  - Any coin or start pulse clears the timeout counter.
  - start with credit>0 -> CHARGE. On that cycle: remain_s = credit*SEC_PER_YUAN, unit counter = SEC_PER_YUAN, rate = hi_pwr latched, tick counter restarted.
  - start with credit=0 is ignored.
  - Exit to DONE with refund=credit on any of:
    - cancel,
    - card low,
    - timeout counter reaching TIMEOUT_S ticks.
- CHARGE:
  - Each tick decrements remain_s and the unit counter by 1 (normal) or 2 (hi_pwr), saturating at 0.
  - When the unit counter reaches 0: credit decrements by 1 and the unit counter reloads SEC_PER_YUAN.
  - remain_s reaching 0 -> DONE with refund=0.
  - cancel or card low -> DONE with refund=credit. The partially consumed unit is forfeited.
  - Coins are ignored.
- DONE:
  - fin=1 for exactly this one cycle; refund is loaded.
  - Next cycle -> IDLE with credit=0 and remain_s=0.
- Precedence within a cycle: reset > (cancel or card low) > timeout > start > coins.
  - A coin coincident with cancel is not counted.
  - A coin coincident with start is not counted; start uses the pre-coin credit.
- Reset mid-session returns to IDLE with no fin and no refund.
- If card is already high at reset release, it does not open a session; a fresh rising edge is required.
- Tick: a one-cycle pulse every TICK_DIV clks. It is free-running in PAY and restarted on CHARGE entry.
- Latency:
  - card edge -> PAY: 1 clk.
  - start -> CHARGE: 1 clk.
  - end condition -> fin: 1 clk.

Decomposition:
- Shared package holds:
  - the state encoding constants (ST_IDLE, ST_PAY, ST_CHARGE, ST_DONE),
  - the coin value constants (COIN_ONE_VAL=1, COIN_TEN_VAL=10).
- One sub-module, tick_gen, parameter TICK_DIV; ports clk, reset, restart, tick. It is instantiated once.

Test Plan (TICK_DIV=4, SEC_PER_YUAN=3, MAX_CREDIT=20, TIMEOUT_S=5):
1. Swipe; coin_one x2; start; hi_pwr=0 -> remain_s=6, credit decrements every 3 ticks. After 6 ticks: fin=1 for one clk, refund=0, then state=IDLE.
2. Swipe; coin_ten x2 then coin_one -> credit saturates at 20. Then coin_one and coin_ten in the same cycle from credit=5 -> credit=16.
3. Swipe; coin_one x3; start; hi_pwr=1; cancel after 2 ticks -> remain_s=5, credit=2 at cancel, fin with refund=2.
4. Swipe; coin_one; no further input for 5 ticks -> auto DONE, refund=1. Separately, start with credit=0 -> stays in PAY.
5. Card drops during CHARGE with credit=4 -> DONE next clk, refund=4. Coin pulse coincident with cancel in PAY -> not counted in refund.
6. Reset asserted mid-CHARGE -> next clk all outputs at reset values, fin never pulses. Card held high through reset release -> stays IDLE.
